shr_ift: RTL and testbench
==========================

// Module: shr_ift
// PURPOSE
//  - Logical right shifter with information-flow tracking (IFT).
//  - Computes c = a >> b and propagates a 32-bit taint label set alongside the data.
//  - One registered pipeline stage.
//  - Used as the shift primitive in taint-tracked datapaths, paired with the other *_ift operators.
// PARAMETERS
//  - WIDTH    4   data width of a, b, c
//  - TAINT_W  32  width of each taint label vector; bit k set = label k present
// PORTS
//  - clk        in   1        clock, rising edge
//  - rst        in   1        synchronous, active-high reset
//  - in_valid   in   1        a/b/a_t/b_t valid this cycle
//  - a          in   WIDTH    value to be shifted
//  - a_t        in   TAINT_W  taint labels of a
//  - b          in   WIDTH    shift amount, unsigned
//  - b_t        in   TAINT_W  taint labels of b
//  - out_valid  out  1        c/c_t hold a new result
//  - c          out  WIDTH    a >> b
//  - c_t        out  TAINT_W  taint labels of c
// BEHAVIOUR
//  - Reset: on a rising clk with rst=1, out_valid=0, c=0, c_t=0. Reset overrides in_valid.
//  - Latency is 1 cycle, with no back-pressure:
//    - in_valid=1 at edge N -> out_valid=1 after edge N, with the result.
//    - in_valid=0 -> out_valid=0; c and c_t hold their last values.
//  - Data:
//    - Logical shift; zeros fill from the MSB.
//    - b is unsigned; b >= WIDTH gives c = 0.
//    - b = 0 gives c = a.
//  - Taint is a set union (bitwise OR) of contributing label vectors. Nothing is ever cleared except as stated below.
//  - Precise taint rule (macro defined):
//    - b_t != 0 -> c_t = a_t | b_t. A tainted shift amount may influence every output bit.
//    - b_t == 0 and b >= WIDTH -> c_t = 0. The output is a constant, independent of a.
//    - b_t == 0 and b < WIDTH -> c_t = a_t.
//  - Conservative taint rule (macro undefined): c_t = a_t | b_t always.
//  - In both modes:
//    - a_t = 0 and b_t = 0 -> c_t = 0.
//    - c_t never contains a label absent from a_t | b_t.
//  - Purely combinational path from inputs to the output registers. No state other than the output registers.
// CONFIGURATION
//  - Macro SHR_IFT_PRECISE_TAINT_EN:
//    - Defined: precise taint rule above.
//    - Undefined: conservative rule, c_t = a_t | b_t.
//  - The data path (c, out_valid, latency) is identical in both builds.
// TESTING
//  - Reset: rst=1 for 2 cycles with in_valid=1, a=4'hF -> out_valid=0, c=0, c_t=0 after each edge.
//  - Untainted shift: a=4'b1100, b=4'd2, a_t=0, b_t=0 -> next cycle c=4'b0011, c_t=0, out_valid=1.
//  - Data taint: a=4'b1010, a_t=32'h1, b=4'd1, b_t=0 -> c=4'b0101, c_t=32'h1 (both builds).
//  - Amount taint: a=4'b1111, a_t=32'h2, b=4'd3, b_t=32'h8000_0000 -> c=4'b0001, c_t=32'h8000_0002.
//  - Overshift: a=4'b1011, a_t=32'h4, b=4'd5, b_t=0 -> c=0.
//    - c_t=0 with SHR_IFT_PRECISE_TAINT_EN.
//    - c_t=32'h4 without it.
//  - Hold: in_valid=0 for 3 cycles after a result -> out_valid=0, c/c_t unchanged.
//    - Then rst=1 mid-stream -> outputs cleared on the next edge.

Source files
------------

// File: rtl/shr_ift.sv
// Logical right shifter with information-flow tracking and one registered stage.
// Build option: define SHR_IFT_PRECISE_TAINT_EN for the precise taint rule (default: conservative).
module shr_ift #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TAINT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [TAINT_W-1:0] a_t,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAINT_W-1:0] b_t,
  output logic               out_valid,
  output logic [WIDTH-1:0]   c,
  output logic [TAINT_W-1:0] c_t
);

  logic               out_valid_d, out_valid_q;
  logic [WIDTH-1:0]   c_d, c_q;
  logic [TAINT_W-1:0] c_t_d, c_t_q;

  logic               overshift;
  logic [WIDTH-1:0]   shifted;
  logic [TAINT_W-1:0] taint;

  // Widen b before comparing so the check is exact for any WIDTH up to 32 bits of amount.
  assign overshift = (32'(b) >= WIDTH);
  assign shifted   = overshift ? '0 : (a >> b);

`ifdef SHR_IFT_PRECISE_TAINT_EN
  // An untainted amount that shifts everything out yields a constant, so no label survives.
  always_comb begin
    taint = a_t;
    if (b_t != '0) begin
      taint = a_t | b_t;
    end else if (overshift) begin
      taint = '0;
    end
  end
`else
  assign taint = a_t | b_t;
`endif

  always_comb begin
    out_valid_d = in_valid;
    c_d         = c_q;
    c_t_d       = c_t_q;
    if (in_valid) begin
      c_d   = shifted;
      c_t_d = taint;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      c_t_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      c_t_q       <= c_t_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign c_t       = c_t_q;

endmodule

// File: tb/tb_shr_ift.sv
// Self-checking bench for shr_ift: directed cases then randomized traffic against a reference model.
module tb_shr_ift;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TAINT_W = 32;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [TAINT_W-1:0] a_t;
  logic [WIDTH-1:0]   b;
  logic [TAINT_W-1:0] b_t;
  logic               out_valid;
  logic [WIDTH-1:0]   c;
  logic [TAINT_W-1:0] c_t;

  int n_assert;
  int n_fail;

  // Reference state: what the outputs must show after the most recent edge.
  logic               exp_valid;
  logic [WIDTH-1:0]   exp_c;
  logic [TAINT_W-1:0] exp_ct;
  logic [TAINT_W-1:0] last_union;

  shr_ift #(
    .WIDTH  (WIDTH),
    .TAINT_W(TAINT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .a_t      (a_t),
    .b        (b),
    .b_t      (b_t),
    .out_valid(out_valid),
    .c        (c),
    .c_t      (c_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logical right shift as integer division by a power of two.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] va,
                                                  input logic [WIDTH-1:0] vb);
    int unsigned num;
    int unsigned amt;
    num = va;
    amt = vb;
    if (amt >= WIDTH) return '0;
    return WIDTH'(num / (32'd1 << amt));
  endfunction

  function automatic logic [TAINT_W-1:0] ref_taint(input logic [TAINT_W-1:0] ta,
                                                    input logic [WIDTH-1:0]   vb,
                                                    input logic [TAINT_W-1:0] tb);
    int unsigned amt;
    amt = vb;
`ifdef SHR_IFT_PRECISE_TAINT_EN
    if (tb != 0) return ta | tb;
    if (amt >= WIDTH) return '0;
    return ta;
`else
    return ta | tb;
`endif
  endfunction

  task automatic check(input string tag);
    n_assert++;
    assert (out_valid === exp_valid) else begin
      n_fail++;
      $error("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, exp_valid);
    end
    n_assert++;
    assert (c === exp_c) else begin
      n_fail++;
      $error("FAIL %s c: got %h expected %h", tag, c, exp_c);
    end
    n_assert++;
    assert (c_t === exp_ct) else begin
      n_fail++;
      $error("FAIL %s c_t: got %h expected %h", tag, c_t, exp_ct);
    end
    if (out_valid === 1'b1) begin
      n_assert++;
      assert ((c_t & ~last_union) === '0) else begin
        n_fail++;
        $error("FAIL %s label_subset: got %h allowed %h", tag, c_t, last_union);
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] va,
                       input logic [TAINT_W-1:0] ta, input logic [WIDTH-1:0] vb,
                       input logic [TAINT_W-1:0] tb, input string tag);
    rst      = r;
    in_valid = v;
    a        = va;
    a_t      = ta;
    b        = vb;
    b_t      = tb;
    @(posedge clk);
    if (r) begin
      exp_valid = 1'b0;
      exp_c     = '0;
      exp_ct    = '0;
    end else if (v) begin
      exp_valid  = 1'b1;
      exp_c      = ref_shift(va, vb);
      exp_ct     = ref_taint(ta, vb, tb);
      last_union = ta | tb;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check(tag);
  endtask

  logic [TAINT_W-1:0] ovs_ct;

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    exp_valid  = 1'b0;
    exp_c      = '0;
    exp_ct     = '0;
    last_union = '0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    a_t        = '0;
    b          = '0;
    b_t        = '0;

    // Reset overrides in_valid.
    cycle(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 4'd0, 32'h1, "reset0");
    cycle(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF, 4'd0, 32'h1, "reset1");

    cycle(1'b0, 1'b1, 4'b1100, 32'h0, 4'd2, 32'h0, "untainted");
    n_assert++;
    assert (c === 4'b0011 && c_t === 32'h0 && out_valid === 1'b1) else begin
      n_fail++;
      $error("FAIL untainted_const: got c=%h c_t=%h v=%0b expected c=3 c_t=0 v=1",
             c, c_t, out_valid);
    end

    cycle(1'b0, 1'b1, 4'b1010, 32'h1, 4'd1, 32'h0, "data_taint");
    n_assert++;
    assert (c === 4'b0101 && c_t === 32'h1) else begin
      n_fail++;
      $error("FAIL data_taint_const: got c=%h c_t=%h expected c=5 c_t=1", c, c_t);
    end

    cycle(1'b0, 1'b1, 4'b1111, 32'h2, 4'd3, 32'h8000_0000, "amount_taint");
    n_assert++;
    assert (c === 4'b0001 && c_t === 32'h8000_0002) else begin
      n_fail++;
      $error("FAIL amount_taint_const: got c=%h c_t=%h expected c=1 c_t=80000002", c, c_t);
    end

    cycle(1'b0, 1'b1, 4'b1011, 32'h4, 4'd5, 32'h0, "overshift");
`ifdef SHR_IFT_PRECISE_TAINT_EN
    ovs_ct = 32'h0;
`else
    ovs_ct = 32'h4;
`endif
    n_assert++;
    assert (c === 4'b0000 && c_t === ovs_ct) else begin
      n_fail++;
      $error("FAIL overshift_const: got c=%h c_t=%h expected c=0 c_t=%h", c, c_t, ovs_ct);
    end

    // Boundary amounts: zero shift and exactly WIDTH.
    cycle(1'b0, 1'b1, 4'b1001, 32'h10, 4'd0, 32'h0, "shift_zero");
    cycle(1'b0, 1'b1, 4'b1111, 32'h20, 4'd4, 32'h0, "shift_width");
    cycle(1'b0, 1'b1, 4'b1111, 32'h20, 4'd15, 32'h40, "shift_max_tainted");
    cycle(1'b0, 1'b1, 4'b0110, 32'h0, 4'd1, 32'h0, "pre_hold");

    // Hold: outputs must not move while in_valid is low, even with busy inputs.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, WIDTH'($urandom), $urandom, WIDTH'($urandom), $urandom, "hold");
    end
    n_assert++;
    assert (c === 4'b0011 && c_t === 32'h0 && out_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL hold_const: got c=%h c_t=%h v=%0b expected c=3 c_t=0 v=0",
             c, c_t, out_valid);
    end

    cycle(1'b0, 1'b1, 4'b1110, 32'h0000_0100, 4'd1, 32'h0200_0000, "pre_midreset");
    cycle(1'b1, 1'b1, 4'b1111, 32'hFF, 4'd0, 32'h0, "midreset");

    // Randomized traffic; taint vectors are often zero to exercise every taint branch.
    for (int i = 0; i < 400; i++) begin
      logic               r, v;
      logic [TAINT_W-1:0] ta, tb;
      r  = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ta = ($urandom_range(0, 2) == 0) ? '0 : TAINT_W'($urandom);
      tb = ($urandom_range(0, 1) == 0) ? '0 : (TAINT_W'(1) << $urandom_range(0, TAINT_W - 1));
      cycle(r, v, WIDTH'($urandom), ta, WIDTH'($urandom), tb, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
